dp_sequencer: RTL and testbench

- Control-side counterpart of the 8-bit two-register datapath (input mux, two-entry register file, 4-op ALU).
- Accepts a byte stream of instructions on a valid/ready handshake and decodes it.
- Sequences the datapath strobes: write enable, register select, ALU opcode, mux select and immediate.
- Returns register contents on an output valid/ready port.

---
 rtl/dp_sequencer.sv | 115 +++++++++++
 tb/tb_dp_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_sequencer.sv
// Instruction sequencer for the 8-bit two-register datapath: decodes a byte stream
// into register-file/ALU strobes and emits register values. Optional SEQ_RETIRE_CNT_EN adds retire_cnt.
module dp_sequencer #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] dp_ra,
    input  logic [DATA_W-1:0] dp_rb,
    output logic              dp_w,
    output logic              dp_reg_sel,
    output logic [1:0]        dp_opcode,
    output logic              dp_mux_sel,
    output logic [DATA_W-1:0] dp_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
`ifdef SEQ_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0]  retire_cnt
`endif
);

    typedef enum logic [1:0] {S_FETCH, S_IMM, S_WB, S_OUT} state_t;

    state_t state;
    logic   dst;
    logic   accept;

    // in_ready is held low while reset is asserted so nothing is taken mid-reset.
    assign in_ready = rst_n && (state == S_FETCH || state == S_IMM);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != S_FETCH);

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values and the block order does not matter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_FETCH;
            dst        <= 1'b0;
            dp_w       <= 1'b0;
            dp_reg_sel <= 1'b0;
            dp_opcode  <= 2'b00;
            dp_mux_sel <= 1'b0;
            dp_imm     <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else begin
            dp_w <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (accept) begin
                        case (in_data[7:6])
                            2'b00: begin
                                dst   <= in_data[0];
                                state <= S_IMM;
                            end
                            2'b01: begin
                                dp_w       <= 1'b1;
                                dp_reg_sel <= in_data[3];
                                dp_opcode  <= in_data[5:4];
                                dp_mux_sel <= 1'b1;
                                state      <= S_WB;
                            end
                            2'b10: begin
                                out_data  <= in_data[0] ? dp_rb : dp_ra;
                                out_valid <= 1'b1;
                                state     <= S_OUT;
                            end
                            default: ;
                        endcase
                    end
                end
                S_IMM: begin
                    if (accept) begin
                        dp_imm     <= in_data;
                        dp_w       <= 1'b1;
                        dp_reg_sel <= dst;
                        dp_opcode  <= 2'b00;
                        dp_mux_sel <= 1'b0;
                        state      <= S_WB;
                    end
                end
                // The datapath write lands on the edge leaving WB, so the next OUT sees it.
                S_WB: state <= S_FETCH;
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_FETCH;
                    end
                end
                default: state <= S_FETCH;
            endcase
        end
    end

`ifdef SEQ_RETIRE_CNT_EN
    logic retire;

    assign retire = (state == S_FETCH && accept && in_data[7:6] == 2'b11)
                 || (state == S_WB)
                 || (state == S_OUT && out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) retire_cnt <= '0;
        else if (retire) retire_cnt <= retire_cnt + CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_dp_sequencer.sv
// Scoreboard bench for dp_sequencer: a program-order reference model predicts writes and
// outputs; a datapath model closes the loop so read-after-write is exercised.
module tb_dp_sequencer;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [DATA_W-1:0] dp_ra;
    logic [DATA_W-1:0] dp_rb;
    logic              dp_w;
    logic              dp_reg_sel;
    logic [1:0]        dp_opcode;
    logic              dp_mux_sel;
    logic [DATA_W-1:0] dp_imm;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              busy;
`ifdef SEQ_RETIRE_CNT_EN
    logic [CNT_W-1:0]  retire_cnt;
`endif

    dp_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .dp_ra      (dp_ra),
        .dp_rb      (dp_rb),
        .dp_w       (dp_w),
        .dp_reg_sel (dp_reg_sel),
        .dp_opcode  (dp_opcode),
        .dp_mux_sel (dp_mux_sel),
        .dp_imm     (dp_imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
`ifdef SEQ_RETIRE_CNT_EN
        ,
        .retire_cnt (retire_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       sel;
        logic       mux;
        logic [1:0] op;
        logic [7:0] val;
    } wr_t;

    wr_t        wr_q[$];
    logic [7:0] out_q[$];
    logic [7:0] ref_r[2];
    logic [7:0] dm_r[2];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         exp_retire = 0;
    bit         rand_ready = 0;

    function automatic logic [7:0] alu(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a ^ b;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Datapath model: two registers, input mux, 4-op ALU.
    assign dp_ra = dm_r[0];
    assign dp_rb = dm_r[1];
    always @(posedge clk)
        if (dp_w) dm_r[dp_reg_sel] <= dp_mux_sel ? alu(dp_opcode, dm_r[0], dm_r[1]) : dp_imm;

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = 1'($urandom % 2);
    end

    // Monitor: pops expectations whenever the DUT presents a write or an output.
    always @(negedge clk) begin
        wr_t        e;
        logic [7:0] v;
        if (rst_n) begin
            if (dp_w) begin
                check("wb_in_ready", in_ready, 0);
                if (wr_q.size() == 0) begin
                    check("unexpected_write", dp_w, 0);
                end else begin
                    e = wr_q.pop_front();
                    v = dp_mux_sel ? alu(dp_opcode, dm_r[0], dm_r[1]) : dp_imm;
                    check("wr_reg_sel", dp_reg_sel, e.sel);
                    check("wr_mux_sel", dp_mux_sel, e.mux);
                    check("wr_opcode", dp_opcode, e.op);
                    check("wr_value", v, e.val);
                end
            end
            if (out_valid) begin
                check("out_in_ready", in_ready, 0);
                if (out_q.size() == 0) begin
                    check("unexpected_out", out_valid, 0);
                end else begin
                    check("out_data", out_data, out_q[0]);
                    if (out_ready) void'(out_q.pop_front());
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one byte and returns #1 after the edge that accepted it.
    task automatic send(input logic [7:0] b, input int gap);
        int t = 0;
        if (gap > 0) idle(gap);
        in_valid = 1'b1;
        in_data  = b;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 100) begin
                check("accept_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    // Issues one instruction and records its architectural effect in program order.
    task automatic issue(input logic [7:0] ins, input logic [7:0] imm, input int gap);
        wr_t e;
        case (ins[7:6])
            2'b00: begin
                send(ins, gap);
                e = '{sel: ins[0], mux: 1'b0, op: 2'b00, val: imm};
                wr_q.push_back(e);
                ref_r[ins[0]] = imm;
                send(imm, gap);
            end
            2'b01: begin
                e = '{sel: ins[3], mux: 1'b1, op: ins[5:4], val: alu(ins[5:4], ref_r[0], ref_r[1])};
                wr_q.push_back(e);
                ref_r[ins[3]] = e.val;
                send(ins, gap);
            end
            2'b10: begin
                out_q.push_back(ref_r[ins[0]]);
                send(ins, gap);
            end
            default: send(ins, gap);
        endcase
        exp_retire++;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (wr_q.size() != 0 || out_q.size() != 0 || busy) begin
            idle(1);
            t++;
            if (t > 200) begin
                check({name, "_drain_timeout"}, 0, 1);
                break;
            end
        end
        idle(1);
        check({name, "_reg0"}, dm_r[0], ref_r[0]);
        check({name, "_reg1"}, dm_r[1], ref_r[1]);
`ifdef SEQ_RETIRE_CNT_EN
        check({name, "_retire_cnt"}, retire_cnt, exp_retire[CNT_W-1:0]);
`endif
    endtask

    task automatic check_reset(input string name);
        check({name, "_in_ready"}, in_ready, 0);
        check({name, "_dp_w"}, dp_w, 0);
        check({name, "_reg_sel"}, dp_reg_sel, 0);
        check({name, "_opcode"}, dp_opcode, 0);
        check({name, "_mux_sel"}, dp_mux_sel, 0);
        check({name, "_imm"}, dp_imm, 0);
        check({name, "_out_valid"}, out_valid, 0);
        check({name, "_out_data"}, out_data, 0);
        check({name, "_busy"}, busy, 0);
`ifdef SEQ_RETIRE_CNT_EN
        check({name, "_retire_cnt"}, retire_cnt, 0);
`endif
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        check("post_reset_in_ready", in_ready, 1);
        wr_q.delete();
        out_q.delete();
        exp_retire = 0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ref_r[i] = '0;
            dm_r[i]  = '0;
        end
        idle(2);
        check_reset("reset");
        release_reset();

        // LOADI reg0 with back-to-back immediate: strobe one cycle after the immediate.
        issue(8'h00, 8'h05, 0);
        check("loadi_dp_w", dp_w, 1);
        check("loadi_imm", dp_imm, 8'h05);
        check("loadi_in_ready", in_ready, 0);
        idle(1);
        check("loadi_dp_w_drop", dp_w, 0);

        // SUB into reg0.
        issue(8'h00, 8'h05, 0);
        issue(8'h01, 8'h03, 0);
        issue(8'h50, 8'h00, 0);
        check("sub_opcode", dp_opcode, 2'b01);
        check("sub_mux_sel", dp_mux_sel, 1);
        idle(1);
        check("sub_result", dm_r[0], 8'h02);

        // OUT reg0 stalled by the consumer for three cycles.
        issue(8'h80, 8'h00, 0);
        for (int i = 0; i < 3; i++) begin
            check("stall_out_valid", out_valid, 1);
            check("stall_out_data", out_data, 8'h02);
            idle(1);
        end
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        check("out_valid_drop", out_valid, 0);
        check("out_back_to_fetch", busy, 0);

        // XOR into reg1 immediately followed by OUT reg1.
        out_ready = 1'b1;
        issue(8'h00, 8'hF0, 0);
        issue(8'h01, 8'h0F, 0);
        issue(8'h78, 8'h00, 0);
        check("xor_opcode", dp_opcode, 2'b11);
        check("xor_reg_sel", dp_reg_sel, 1);
        issue(8'h81, 8'h00, 0);
        check("raw_out_data", out_data, 8'hFF);
        drain("directed");

        // Reset while waiting for an immediate.
        send(8'h01, 0);
        #2 rst_n = 1'b0;
        #1 check_reset("reset_mid_imm");
        release_reset();
        issue(8'hC0, 8'h00, 0);
        idle(3);
        check("nop_no_write", dp_w, 0);

        // Reset while an output is pending.
        out_ready = 1'b0;
        issue(8'h81, 8'h00, 0);
        idle(2);
        #2 rst_n = 1'b0;
        #1 check_reset("reset_mid_out");
        release_reset();

        // Retire counting: 3 NOPs, LOADI, OUT.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) issue(8'hC0, 8'h00, 0);
        issue(8'h01, 8'h3C, 0);
        issue(8'h81, 8'h00, 0);
        drain("retire");

        // Randomised program with random gaps and consumer back-pressure; counter wraps.
        rand_ready = 1;
        for (int i = 0; i < 150; i++)
            issue(8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
        drain("random");
        rand_ready = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
